// File: rtl/dbus_uart_if.sv
// dbus_uart_if: data-side bus between the MIPS core and the dbus_uart target.
//   addr      : byte address (core aluresult)
//   writedata : store data
//   memwrite  : store strobe, one cycle per store
//   readdata  : combinational load data back to the core
// Modports: master (core side), slave (dbus_uart side).
interface dbus_uart_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] writedata;
    logic              memwrite;
    logic [DATA_W-1:0] readdata;

    modport master (
        output addr,
        output writedata,
        output memwrite,
        input  readdata
    );

    modport slave (
        input  addr,
        input  writedata,
        input  memwrite,
        output readdata
    );
endinterface

// File: rtl/dbus_uart.sv
// dbus_uart: data bus target for the single-cycle MIPS core. Decodes the
// data address into a word-addressed RAM and a memory-mapped UART
// transmitter (TXDATA at UART_BASE, STATUS at UART_BASE+4).
//
// Ports:
//   clk     : system clock, all state on posedge
//   rst     : synchronous active-high reset
//   bus     : dbus_uart_if.slave (addr, writedata, memwrite, readdata)
//   txd     : UART serial out, idle high, registered
//   tx_busy : transmitter active or buffer holding data
//
// STATUS word: {0..., ovf, empty, full, busy}
//
// Build option: define DBUS_UART_TXFIFO_EN to replace the single holding
// register with a 4-entry circular FIFO. Register map is unchanged.
//
// TX FSM states:
//   state   | meaning
//   S_IDLE  | line high, waiting for a buffered byte
//   S_START | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (high); chains straight into S_START if more data
module dbus_uart #(
    parameter int                DATA_W       = 32,
    parameter int                DMEM_DEPTH   = 256,
    parameter int                CLKS_PER_BIT = 16,
    parameter logic [DATA_W-1:0] UART_BASE    = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    dbus_uart_if.slave  bus,
    output logic        txd,
    output logic        tx_busy
);

    localparam int                AW          = $clog2(DMEM_DEPTH);
    localparam int                BW          = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]     BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [DATA_W-1:0] DMEM_BYTES  = DATA_W'(DMEM_DEPTH * 4);
    localparam logic [DATA_W-1:0] STATUS_ADDR = UART_BASE + DATA_W'(4);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    // ---------------- address decode ----------------
    logic          dmem_hit;
    logic          txdata_hit;
    logic          status_hit;
    logic [AW-1:0] word_idx;
    logic          tx_wr;
    logic          status_wr;

    assign dmem_hit   = bus.addr < DMEM_BYTES;
    assign txdata_hit = bus.addr == UART_BASE;
    assign status_hit = bus.addr == STATUS_ADDR;
    assign word_idx   = bus.addr[AW+1:2];
    assign tx_wr      = bus.memwrite && txdata_hit;
    assign status_wr  = bus.memwrite && status_hit;

    // ---------------- data RAM (not reset) ----------------
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (bus.memwrite && dmem_hit)
            dmem[word_idx] <= bus.writedata;
    end

    // ---------------- TX buffer ----------------
    logic       buf_full;
    logic       buf_empty;
    logic [7:0] head_byte;
    logic       enq;
    logic       deq;
    logic       ovf;

    // A write into a full buffer still lands if the FSM drains an entry
    // on the same edge.
    assign enq = tx_wr && (!buf_full || deq);

`ifdef DBUS_UART_TXFIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;

    assign buf_full  = count == 3'd4;
    assign buf_empty = count == 3'd0;
    assign head_byte = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq)
            fifo_mem[wr_ptr] <= bus.writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 2'd1;
            if (deq)
                rd_ptr <= rd_ptr + 2'd1;
            case ({enq, deq})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic       hold_valid;
    logic [7:0] hold_byte;

    assign buf_full  = hold_valid;
    assign buf_empty = !hold_valid;
    assign head_byte = hold_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
        end else if (enq) begin
            hold_valid <= 1'b1;
            hold_byte  <= bus.writedata[7:0];
        end else if (deq) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Sticky overflow; cleared by any STATUS write. A STATUS write and a
    // TXDATA write cannot coincide since the bus carries one address.
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (status_wr)
            ovf <= 1'b0;
        else if (tx_wr && !enq)
            ovf <= 1'b1;
    end

    // ---------------- TX FSM ----------------
    tx_state_t state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          txd_nxt;
    logic          bit_end;

    assign bit_end = baud_cnt == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            txd      <= txd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        deq       = 1'b0;
        txd_nxt   = 1'b1;

        case (state)
            S_IDLE: begin
                if (!buf_empty) begin
                    deq       = 1'b1;
                    shift_nxt = head_byte;
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = '0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_nxt = BAUD_RELOAD;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!buf_empty) begin
                        deq       = 1'b1;
                        shift_nxt = head_byte;
                        baud_nxt  = BAUD_RELOAD;
                        bit_nxt   = '0;
                        state_nxt = S_START;
                    end else begin
                        baud_nxt  = '0;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // txd is registered: drive the level of the state being entered.
        case (state_nxt)
            S_START: txd_nxt = 1'b0;
            S_DATA:  txd_nxt = shift_nxt[0];
            default: txd_nxt = 1'b1;
        endcase
    end

    assign tx_busy = (state != S_IDLE) || !buf_empty;

    // ---------------- read mux ----------------
    always_comb begin
        bus.readdata = '0;
        if (dmem_hit)
            bus.readdata = dmem[word_idx];
        else if (status_hit)
            bus.readdata = {{(DATA_W-4){1'b0}}, ovf, buf_empty, buf_full, tx_busy};
    end

endmodule

// File: tb/tb_dbus_uart.sv
// tb_dbus_uart: self-checking bench for dbus_uart with CLKS_PER_BIT=4.
// Expected UART bytes are queued as they are written; a serial monitor
// decodes txd frames and pops/compares them.
module tb_dbus_uart;

    localparam int          C         = 4;
    localparam logic [31:0] UART_BASE = 32'hFFFF_FF00;
    localparam logic [31:0] TXDATA    = UART_BASE;
    localparam logic [31:0] STATUS    = UART_BASE + 32'd4;
    localparam logic [31:0] UNMAPPED  = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst;
    logic txd;
    logic tx_busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    int         exp_frames = 0;

    dbus_uart_if #(.DATA_W(32)) bus ();

    dbus_uart #(
        .DATA_W      (32),
        .DMEM_DEPTH  (256),
        .CLKS_PER_BIT(C),
        .UART_BASE   (UART_BASE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .txd    (txd),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] v;
        int k;
        for (int i = 0; i < 40; i++) begin
            k = i / C;
            if (k == 0)      v[i] = 1'b0;
            else if (k == 9) v[i] = 1'b1;
            else             v[i] = b[k-1];
        end
        return v;
    endfunction

    // ---------------- serial monitor ----------------
    int         m_cnt    = 0;
    bit         m_active = 0;
    int         m_frames = 0;
    logic [7:0] m_byte;
    logic [7:0] m_exp;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            m_active = 0;
            m_cnt    = 0;
        end else if (!m_active) begin
            if (txd === 1'b0) begin
                m_active = 1;
                m_cnt    = 0;
            end
        end else begin
            m_cnt++;
        end
        if (m_active && (m_cnt % C) == C / 2) begin
            if (m_cnt / C == 0) begin
                chk("rx_start_bit", 64'(txd), 64'd0);
            end else if (m_cnt / C <= 8) begin
                m_byte[m_cnt / C - 1] = txd;
            end else begin
                chk("rx_stop_bit", 64'(txd), 64'd1);
                m_frames++;
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected_byte", 64'(m_byte), 64'hFFFF);
                end else begin
                    m_exp = exp_q.pop_front();
                    chk("rx_byte", 64'(m_byte), 64'(m_exp));
                end
            end
        end
        if (m_active && m_cnt == 10 * C - 1)
            m_active = 0;
    end

    // ---------------- bus helpers ----------------
    task automatic tx_push(input logic [7:0] b);
        exp_q.push_back(b);
        exp_frames++;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr      = a;
        bus.writedata = d;
        bus.memwrite  = 1'b1;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.memwrite  = 1'b0;
        bus.addr      = UNMAPPED;
        bus.writedata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.addr     = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic wait_fall();
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (txd === 1'b0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen)
            chk("wait_fall_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) begin
                done = 1;
                break;
            end
        end
        if (!done)
            chk("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    // Called at the negedge holding the first start-bit sample.
    task automatic capture_frame(input string tag, input logic [7:0] b);
        logic [39:0] obs;
        for (int i = 0; i < 40; i++) begin
            obs[i] = txd;
            @(negedge clk);
        end
        chk(tag, 64'(obs), 64'(frame_bits(b)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [31:0] rd;

    initial begin
        rst           = 1'b1;
        bus.addr      = UNMAPPED;
        bus.writedata = '0;
        bus.memwrite  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 64'(txd), 64'd1);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        rst = 1'b0;

        bus_read(STATUS, rd);
        chk("status_after_rst", 64'(rd), 64'h4);

        // DMEM
        bus_write(32'h10, 32'hDEAD_BEEF);
        bus_write(32'h0, 32'h1234_5678);
        bus_write(32'h3FC, 32'hCAFE_F00D);
        bus_write(32'h400, 32'hFFFF_FFFF);
        bus_idle();
        bus_read(32'h10, rd);   chk("dmem_rd_10", 64'(rd), 64'hDEAD_BEEF);
        bus_read(32'h12, rd);   chk("dmem_rd_12", 64'(rd), 64'hDEAD_BEEF);
        bus_read(32'h2000, rd); chk("unmapped_rd", 64'(rd), 64'h0);
        bus_read(32'h0, rd);    chk("dmem_rd_0", 64'(rd), 64'h1234_5678);
        bus_read(32'h3FF, rd);  chk("dmem_rd_last", 64'(rd), 64'hCAFE_F00D);
        bus_read(32'h400, rd);  chk("dmem_rd_oob", 64'(rd), 64'h0);
        bus_read(TXDATA, rd);   chk("txdata_rd", 64'(rd), 64'h0);

        // Single frame with exact latency and shape
        tx_push(8'hA5);
        bus_write(TXDATA, 32'hFFFF_FFA5);
        bus_idle();
        chk("lat_pre_txd", 64'(txd), 64'd1);
        chk("lat_pre_busy", 64'(tx_busy), 64'd1);
        @(negedge clk);
        chk("lat_fall", 64'(txd), 64'd0);
        capture_frame("frame_a5", 8'hA5);
        chk("a5_done_busy", 64'(tx_busy), 64'd0);
        chk("a5_done_txd", 64'(txd), 64'd1);

`ifndef DBUS_UART_TXFIFO_EN
        // Overflow with holding register
        tx_push(8'h11);
        tx_push(8'h22);
        bus_write(TXDATA, 32'h11);
        bus_write(TXDATA, 32'h22);
        bus_write(TXDATA, 32'h33);
        bus_idle();
        bus_read(STATUS, rd);
        chk("ovf_status", 64'(rd), 64'hB);
        bus_write(STATUS, 32'h0);
        bus_idle();
        bus_read(STATUS, rd);
        chk("ovf_cleared", 64'(rd), 64'h3);
        wait_idle(400);
`else
        // FIFO: five back-to-back writes fit, sixth overflows
        for (int i = 0; i < 5; i++) begin
            tx_push(8'(8'h41 + i));
            bus_write(TXDATA, 32'(8'h41 + i));
        end
        bus_idle();
        bus_read(STATUS, rd);
        chk("fifo_full_status", 64'(rd), 64'h3);
        bus_write(TXDATA, 32'h99);
        bus_idle();
        bus_read(STATUS, rd);
        chk("fifo_ovf_status", 64'(rd), 64'hB);
        bus_write(STATUS, 32'h0);
        bus_idle();
        bus_read(STATUS, rd);
        chk("fifo_ovf_cleared", 64'(rd), 64'h3);
        wait_idle(600);
`endif
        bus_read(STATUS, rd);
        chk("idle_status", 64'(rd), 64'h4);

        // Back-to-back frames, no gap beyond the stop bit
        tx_push(8'h3C);
        tx_push(8'hC3);
        bus_write(TXDATA, 32'h3C);
        bus_write(TXDATA, 32'hC3);
        bus_idle();
        wait_fall();
        capture_frame("b2b_first", 8'h3C);
        capture_frame("b2b_second", 8'hC3);
        chk("b2b_done_busy", 64'(tx_busy), 64'd0);
        chk("b2b_done_txd", 64'(txd), 64'd1);

        // Reset during data bit 3
        tx_push(8'h5A);
        bus_write(TXDATA, 32'h5A);
        bus_idle();
        wait_fall();
        repeat (C + 3 * C + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_txd", 64'(txd), 64'd1);
        chk("midrst_busy", 64'(tx_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_frames--;
        bus_read(STATUS, rd);
        chk("midrst_status", 64'(rd), 64'h4);
        tx_push(8'h96);
        bus_write(TXDATA, 32'h96);
        bus_idle();
        wait_fall();
        capture_frame("post_rst_frame", 8'h96);
        chk("post_rst_busy", 64'(tx_busy), 64'd0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("frame_count", 64'(m_frames), 64'(exp_frames));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_uart.md
Name: dbus_uart

Overview:
- Data-side bus target directly downstream of the single-cycle MIPS core.
- Consumes the core's data address (aluresult), writedata and memwrite; returns readdata in the same cycle.
- Decodes the address into a word-addressed data RAM and a memory-mapped UART transmitter with buffered, serialised output on txd.

Parameters:
DATA_W, 32, bus data/address width (matches `DATA_W in def.h)
DMEM_DEPTH, 256, data RAM depth in words (power of two)
CLKS_PER_BIT, 16, clk cycles per UART bit (>=2)
UART_BASE, 32'hFFFF_FF00, base of UART register window

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous active-high reset
addr  input  DATA_W  byte address from core aluresult
writedata  input  DATA_W  store data from core
memwrite  input  1  store strobe, one cycle per store
readdata  output  DATA_W  combinational load data to core
txd  output  1  UART serial out, idle high
tx_busy  output  1  FSM not IDLE or buffer non-empty

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high; sampled on posedge only.
- Decode:
  - DMEM hit: addr < DMEM_DEPTH*4; word index addr[log2(DMEM_DEPTH)+1:2]; addr[1:0] ignored.
  - TXDATA: addr == UART_BASE.
  - STATUS: addr == UART_BASE+4.
  - Anything else: reads return 0, writes ignored.
- DMEM: asynchronous read, synchronous write on posedge when memwrite & DMEM hit. Contents not cleared by rst.
- TXDATA read returns 0. Write enqueues writedata[7:0]; upper bits ignored.
- STATUS read: {28'b0, ovf, empty, full, busy}; bit0 = tx_busy. Read has no side effects. Any write to STATUS clears ovf.
- Buffer: single holding register (see Optional Feature).
  - full = holding valid.
  - Write accepted iff !full, or FSM dequeues in the same cycle.
  - Rejected write sets sticky ovf; data is discarded.
- TX FSM (registered txd):
  - IDLE: txd=1. Buffer non-empty at posedge -> dequeue byte into shift reg, go START.
  - START: txd=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; 3-bit bit counter -> STOP after bit 7.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then: buffer non-empty -> dequeue, go START directly (back-to-back, no idle gap); else IDLE.
- Frame: exactly 10*CLKS_PER_BIT cycles. Baud counter reloads at every bit boundary.
- Latency: TXDATA write at edge N -> txd falls at edge N+1 when IDLE.
- Simultaneous events:
  - Write with dequeue in same cycle while full: new byte accepted, no ovf.
  - STATUS write together with an overflowing TXDATA write is impossible (single address per cycle).
- Reset (including mid-frame): FSM->IDLE, txd=1 at next edge, buffer emptied, ovf=0, counters=0, tx_busy=0. The partial frame is abandoned.
- Reset values: txd=1, tx_busy=0. readdata follows addr combinationally (STATUS reads 32'h4 after reset).

Optional Feature:
- Macro: DBUS_UART_TXFIFO_EN.
- Defined: holding register replaced by 4-entry circular FIFO (2-bit rd/wr pointers plus count).
  - full = count==4; empty = count==0.
  - Enqueue and dequeue in the same cycle keep count unchanged; allowed when full.
  - Pointers wrap 3->0.
- Undefined: single-entry holding register as above; full = valid. Register map unchanged.

Test Plan:
- Reset, then DMEM access: store 32'hDEADBEEF @ 0x10, load 0x10 -> readdata 32'hDEADBEEF; load 0x12 -> same word; load 0x2000 -> 0.
- Single frame: write 8'hA5 to TXDATA (CLKS_PER_BIT=4) -> txd low 4 cycles from next edge, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; tx_busy low after 40 cycles.
- Overflow: write 0x11, 0x22, 0x33 on consecutive cycles (no FIFO) -> 0x11 sent, 0x22 held, 0x33 dropped; STATUS reads ovf=1 (bit3); STATUS write -> ovf=0.
- Back-to-back frames: two queued bytes -> exactly 2*10*CLKS_PER_BIT cycles of activity, no idle-high gap beyond the stop bit.
- Reset mid-frame: assert rst during DATA bit 3 -> txd=1 next edge; STATUS reads 32'h4; subsequent write transmits a clean full frame.
- With DBUS_UART_TXFIFO_EN: write 5 bytes back-to-back while IDLE -> first dequeued immediately, 4 buffered, no ovf; 6th write during frame 1 -> ovf=1; bytes emitted in order.
